// File: rtl/iris_feature_sequencer_pkg.sv
// Shared constants and state encoding for the iris feature sequencer and the
// classifier that sits beside it.
package iris_feature_sequencer_pkg;

    localparam int DEF_N_FEAT = 4;
    localparam int DEF_FEAT_W = 4;
    localparam int DEF_CLS_W  = 2;
    localparam int DEF_SETTLE = 1;

    typedef enum logic [1:0] {
        COLLECT,
        SETTLE_W,
        OUT,
        DRAIN
    } state_t;

endpackage

// File: rtl/iris_feature_sequencer_if.sv
// Feature stream in, class result out; the sequencer takes the slave side.
interface iris_feature_sequencer_if
    import iris_feature_sequencer_pkg::*;
#(
    parameter int FEAT_W = DEF_FEAT_W,
    parameter int CLS_W  = DEF_CLS_W
);
    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [CLS_W-1:0]  m_class;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class
    );
endinterface

// File: rtl/iris_feature_sequencer.sv
// Gathers N_FEAT feature beats into a frame, presents it to an external
// combinational classifier, waits SETTLE cycles and returns the class index.
module iris_feature_sequencer
    import iris_feature_sequencer_pkg::*;
#(
    parameter int N_FEAT = DEF_N_FEAT,
    parameter int FEAT_W = DEF_FEAT_W,
    parameter int CLS_W  = DEF_CLS_W,
    parameter int SETTLE = DEF_SETTLE
)(
    input  logic                     clk,
    input  logic                     rst,
    iris_feature_sequencer_if.slave  bus,
    output logic [N_FEAT*FEAT_W-1:0] inp,
    input  logic [CLS_W-1:0]         cls_in,
    output logic                     err_len
);

    localparam int                TOT_W       = N_FEAT * FEAT_W;
    localparam int                CNT_W       = $clog2(N_FEAT) + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(N_FEAT - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [TOT_W-1:0]  SLOT_MASK   = TOT_W'({FEAT_W{1'b1}});

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [3:0]         settle_cnt;
    logic [TOT_W-1:0]   shadow;
    logic [TOT_W-1:0]   shadow_upd;
    logic [31:0]        slot_lsb;
    logic               m_valid_q;
    logic [CLS_W-1:0]   m_class_q;
    logic               accept;

    // NOTE: s_ready is decoded from state and forced low by rst itself, so it is
    // already 1 in the very first cycle after release instead of one edge later.
    assign bus.s_ready = !rst && (state == COLLECT || state == DRAIN);
    assign accept      = bus.s_valid && bus.s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_class = m_class_q;

    // Current beat dropped into its slot; also the full frame on the final beat.
    assign slot_lsb   = 32'(beat_cnt) * 32'(FEAT_W);
    assign shadow_upd = (shadow & ~(SLOT_MASK << slot_lsb))
                      | (TOT_W'(bus.s_data) << slot_lsb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            beat_cnt   <= '0;
            settle_cnt <= '0;
            shadow     <= '0;
            inp        <= '0;
            m_valid_q  <= 1'b0;
            m_class_q  <= '0;
            err_len    <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (beat_cnt == LAST_IDX) begin
                            beat_cnt <= '0;
                            if (bus.s_last) begin
                                shadow     <= shadow_upd;
                                inp        <= shadow_upd;
                                settle_cnt <= SETTLE_LOAD;
                                state      <= SETTLE_W;
                            end else begin
                                err_len <= 1'b1;
                                state   <= DRAIN;
                            end
                        end else if (bus.s_last) begin
                            err_len  <= 1'b1;
                            beat_cnt <= '0;
                        end else begin
                            shadow   <= shadow_upd;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                SETTLE_W: begin
                    if (settle_cnt == 4'd0) begin
                        m_class_q <= cls_in;
                        m_valid_q <= 1'b1;
                        state     <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= COLLECT;
                    end
                end
                DRAIN: begin
                    if (accept && bus.s_last) begin
                        beat_cnt <= '0;
                        state    <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_iris_feature_sequencer.sv
// Scoreboard bench: frames are pushed as expected (packed frame, argmax class,
// commit cycle) and a monitor checks every result the sequencer presents.
module tb_iris_feature_sequencer;
    import iris_feature_sequencer_pkg::*;

    localparam int N_FEAT = DEF_N_FEAT;
    localparam int FEAT_W = DEF_FEAT_W;
    localparam int CLS_W  = DEF_CLS_W;
    localparam int SETTLE = 4;
    localparam int TOT_W  = N_FEAT * FEAT_W;
    localparam int TMO    = 200;

    typedef int frame_t [N_FEAT];
    typedef struct {
        logic [TOT_W-1:0] frame;
        logic [CLS_W-1:0] cls;
        int               stamp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [TOT_W-1:0] inp;
    logic [CLS_W-1:0] cls_in;
    logic             err_len;

    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               err_exp = 0;
    int               err_seen = 0;
    bit               stall = 1'b0;
    exp_t             exp_q[$];
    logic [TOT_W-1:0] model_inp = '0;
    frame_t           fr;

    iris_feature_sequencer_if #(.FEAT_W(FEAT_W), .CLS_W(CLS_W)) bus ();

    iris_feature_sequencer #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .inp(inp), .cls_in(cls_in), .err_len(err_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Classifier beside the sequencer: argmax of the features, lowest index on ties.
    always_comb begin
        logic [FEAT_W-1:0] best;
        logic [FEAT_W-1:0] cur;
        best   = FEAT_W'(inp);
        cls_in = '0;
        for (int k = 1; k < N_FEAT; k++) begin
            cur = FEAT_W'(inp >> (k * FEAT_W));
            if (cur > best) begin
                best   = cur;
                cls_in = CLS_W'(k);
            end
        end
    end

    function automatic logic [CLS_W-1:0] ref_class(input frame_t f);
        int mx = 0;
        foreach (f[k]) if (f[k] > mx) mx = f[k];
        foreach (f[k]) if (f[k] == mx) return CLS_W'(k);
        return '0;
    endfunction

    function automatic logic [TOT_W-1:0] ref_pack(input frame_t f);
        logic [TOT_W-1:0] v = '0;
        foreach (f[k]) v = v + (TOT_W'(f[k]) << (FEAT_W * k));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_beat(input int d, input bit l);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = FEAT_W'(d);
        bus.s_last  = l;
        while (!bus.s_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            total++;
            bad++;
            $display("FAIL beat_accept: s_ready stayed 0, expected 1 within %0d cycles", TMO);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic idle();
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic push_exp(input frame_t f);
        model_inp = ref_pack(f);
        exp_q.push_back('{frame: model_inp, cls: ref_class(f), stamp: cyc});
    endtask

    task automatic send_good(input frame_t f, input bit gaps);
        for (int k = 0; k < N_FEAT; k++) begin
            send_beat(f[k], k == N_FEAT - 1);
            if (gaps && k < N_FEAT - 1) idle();
        end
        push_exp(f);
    endtask

    task automatic send_short(input int len);
        for (int k = 0; k < len; k++) send_beat($urandom_range(0, 15), k == len - 1);
        err_exp++;
    endtask

    task automatic send_long(input int extra);
        for (int k = 0; k < N_FEAT; k++) send_beat($urandom_range(0, 15), 1'b0);
        err_exp++;
        #1 check("drain_sready", bus.s_ready, 1);
        for (int j = 0; j < extra; j++) send_beat($urandom_range(0, 15), j == extra - 1);
        check("drain_inp_hold", inp, model_inp);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Result consumer with random back-pressure unless a stall is requested.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks every presented result against the scoreboard head.
    initial begin
        bit               prev_valid = 1'b0;
        logic [CLS_W-1:0] held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
                continue;
            end
            if (err_len) err_seen++;
            if (bus.m_valid) begin
                check("sready_low_in_out", bus.s_ready, 0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: m_valid=1 class=%0d, expected no result", bus.m_class);
                    end else begin
                        check("latency", cyc - exp_q[0].stamp, SETTLE);
                        check("class", bus.m_class, exp_q[0].cls);
                        check("inp_frame", inp, exp_q[0].frame);
                    end
                end else begin
                    check("class_hold", bus.m_class, held);
                end
                held = bus.m_class;
                if (bus.m_ready) begin
                    if (exp_q.size() != 0) exp_q.delete(0);
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = 1'b1;
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n;
        int               kind;
        int               seen;
        logic [CLS_W-1:0] stall_cls;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_inp", inp, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_class", bus.m_class, 0);
        check("rst_err_len", err_len, 0);
        check("rst_s_ready", bus.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("sready_after_release", bus.s_ready, 1);

        // All-zero frame classifies as index 0.
        fr = '{0, 0, 0, 0};
        send_good(fr, 1'b0);

        // Partial frames never reach inp.
        fr = '{1, 2, 3, 4};
        for (int k = 0; k < N_FEAT - 1; k++) begin
            send_beat(fr[k], 1'b0);
            check("inp_hold_partial", inp, model_inp);
        end
        send_beat(fr[N_FEAT-1], 1'b1);
        check("inp_commit", inp, TOT_W'(16'h4321));
        push_exp(fr);

        // Early s_last: one error pulse, then a normal frame.
        send_short(2);
        @(negedge clk);
        #2 check("err_short", err_seen, err_exp);
        fr = '{9, 3, 14, 2};
        send_good(fr, 1'b1);

        // Missing s_last: error, drain, then a normal frame.
        send_long(2);
        @(negedge clk);
        #2 check("err_long", err_seen, err_exp);
        fr = '{5, 11, 0, 6};
        send_good(fr, 1'b0);
        wait_empty();

        // Result held under back-pressure; beats offered meanwhile are refused.
        stall = 1'b1;
        fr = '{3, 8, 8, 1};
        stall_cls = ref_class(fr);
        send_good(fr, 1'b0);
        n = 0;
        while (!bus.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_result_seen", bus.m_valid, 1);
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = FEAT_W'($urandom_range(0, 15));
            bus.s_last  = 1'($urandom_range(0, 1));
            #1;
            check("stall_sready", bus.s_ready, 0);
            check("stall_mvalid", bus.m_valid, 1);
            check("stall_class", bus.m_class, stall_cls);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        stall = 1'b0;

        // Random mix of good, short and long frames.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            foreach (fr[k]) fr[k] = $urandom_range(0, (1 << FEAT_W) - 1);
            if (kind == 0)      send_short($urandom_range(1, N_FEAT - 1));
            else if (kind == 1) send_long($urandom_range(1, 3));
            else                send_good(fr, 1'b1);
            idle();
        end
        wait_empty();

        // Leave a nonzero class behind, then reset in the middle of settling.
        fr = '{1, 3, 9, 2};
        send_good(fr, 1'b0);
        wait_empty();
        check("pre_reset_class", bus.m_class, 2);
        fr = '{6, 13, 4, 7};
        send_good(fr, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        model_inp = '0;
        #1;
        check("midrst_inp", inp, 0);
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_m_class", bus.m_class, 0);
        check("midrst_err_len", err_len, 0);
        check("midrst_s_ready", bus.s_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("sready_after_midrst", bus.s_ready, 1);
        seen = 0;
        repeat (SETTLE + 4) begin
            @(negedge clk);
            #1;
            if (bus.m_valid) seen++;
        end
        check("no_result_after_reset", seen, 0);

        fr = '{7, 7, 1, 0};
        send_good(fr, 1'b1);
        wait_empty();
        repeat (3) @(negedge clk);
        #2 check("err_len_count", err_seen, err_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iris_feature_sequencer.md
IRIS_FEATURE_SEQUENCER -- requirements
Module: iris_feature_sequencer

Interface
REQ-001 SHALL have parameter N_FEAT, default 4, number of input features per frame.
REQ-002 SHALL have parameter FEAT_W, default 4, feature width in bits (unsigned).
REQ-003 SHALL have parameter CLS_W, default 2, class index width.
REQ-004 SHALL have parameter SETTLE, default 1 (legal 1..15), cycles allowed for classifier settling.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  reset.
REQ-008 s_valid  input  1  feature beat valid.
REQ-009 s_ready  output  1  feature beat accepted when s_valid&s_ready.
REQ-010 s_data  input  FEAT_W  one feature.
REQ-011 s_last  input  1  marks final beat of a frame.
REQ-012 inp  output  N_FEAT*FEAT_W  packed vector to the combinational classifier.
REQ-013 cls_in  input  CLS_W  argmax index returned by the classifier.
REQ-014 m_valid  output  1  result valid.
REQ-015 m_ready  input  1  result consumer ready.
REQ-016 m_class  output  CLS_W  registered class index.
REQ-017 err_len  output  1  one-cycle pulse on malformed frame.

Function
REQ-018 SHALL implement states COLLECT, SETTLE_W, OUT, DRAIN.
REQ-019 s_ready SHALL be 1 in COLLECT and DRAIN, 0 in SETTLE_W and OUT.
REQ-020 Beat k (0-based) of a frame SHALL occupy bits [FEAT_W*k+FEAT_W-1 : FEAT_W*k] of a shadow register.
REQ-021 inp SHALL change only on acceptance of a well-formed final beat: shadow plus that beat, committed in one edge; partial frames SHALL never appear on inp.
REQ-022 Well-formed: s_last asserted exactly on beat N_FEAT-1; on commit, state -> SETTLE_W, settle counter loaded with SETTLE-1.
REQ-023 SETTLE_W SHALL decrement each cycle; at the cycle where the counter is 0, cls_in SHALL be registered into m_class and state -> OUT (m_valid rises exactly SETTLE cycles after the commit edge).
REQ-024 OUT: m_valid=1, m_class stable; on m_valid&m_ready -> COLLECT, beat counter 0, next cycle m_valid=0.
REQ-025 s_last on beat k<N_FEAT-1: err_len pulses, frame discarded, beat counter 0, stay COLLECT, inp unchanged.
REQ-026 Beat N_FEAT-1 without s_last: err_len pulses, frame discarded, state -> DRAIN.
REQ-027 DRAIN SHALL accept and discard beats; the beat carrying s_last returns to COLLECT with beat counter 0; no further err_len in DRAIN.
REQ-028 Beat counter SHALL be ceil(log2(N_FEAT))+1 bits wide and never wrap past N_FEAT-1.
REQ-029 Sequencer SHALL impose no arithmetic on features; data passes bit-exact.

Reset
REQ-030 On rst: state COLLECT, beat counter 0, shadow 0, inp 0, m_class 0, m_valid 0, err_len 0, settle counter 0.
REQ-031 rst asserted mid-frame or in SETTLE_W/OUT SHALL discard all in-flight data with no result emitted after release.
REQ-032 s_ready SHALL be 0 while rst is asserted and 1 in the first cycle after release.

Structure
REQ-033 Shared package SHALL hold N_FEAT, FEAT_W, CLS_W defaults and the state enumeration; the classifier reads the same constants.
REQ-034 No sub-module; the classifier SHALL be instantiated beside this block by the parent, inp -> classifier input, classifier output -> cls_in.

Verification
REQ-035 Frame 0,0,0,0 (last on beat 3) with real classifier attached, SETTLE=1 -> inp=16'h0000, m_valid one cycle after commit, m_class=0.
REQ-036 Beats 1,2,3,4 -> inp=16'h4321 only after beat 3 edge; inp unchanged during beats 0-2.
REQ-037 s_last on beat 1 -> err_len single pulse, no m_valid, next well-formed frame classified normally.
REQ-038 4 beats without s_last, then 2 beats with s_last on second -> one err_len pulse, DRAIN entered then exited, inp unchanged.
REQ-039 m_ready held 0 for 10 cycles in OUT -> m_valid and m_class stable, s_ready 0, s_valid beats not accepted.
REQ-040 rst asserted during SETTLE_W (SETTLE=4) -> all outputs 0, no m_valid after release, s_ready 1 first cycle after release.
